// File: rtl/m6809_sysctl_pkg.sv
// Shared types and helpers for the 6809 system-control CPLD slice.
package m6809_sysctl_pkg;

  localparam int unsigned PAGE_W = 8;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } wait_state_e;

  // Extract field idx (w bits wide) from a packed parameter array zero-extended to 64 bits.
  function automatic logic [PAGE_W-1:0] field_get(input logic [63:0] vec,
                                                  input int unsigned idx,
                                                  input int unsigned w);
    logic [63:0] sh;
    logic [63:0] msk;
    sh  = vec >> (idx * w);
    msk = (64'd1 << w) - 64'd1;
    return PAGE_W'(sh & msk);
  endfunction

endpackage

// File: rtl/m6809_led_stretch.sv
// Activity LED pulse stretcher: event saturates a down-counter, LED lit while nonzero.
module m6809_led_stretch #(
  parameter int unsigned LED_W = 16
) (
  input  logic HSCLK,
  input  logic RST_B,
  input  logic event_in,
  output logic led_b
);

  logic [LED_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (event_in) begin
      cnt_d = '1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LED_W'(1);
    end
    led_b = ~(event_in | (cnt_q != '0));
  end

  always_ff @(posedge HSCLK or negedge RST_B) begin
    if (!RST_B) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/m6809_sysctl.sv
// 6809 card system control: page decode, wait-state MRDY stretch, vector remap, activity LEDs.
// Optional feature: define M6809_SYSCTL_VECTOR_REMAP_EN to flip SYS_A8 on vector fetches.
module m6809_sysctl
  import m6809_sysctl_pkg::*;
#(
  parameter int unsigned                   NUM_CS  = 4,
  parameter logic [NUM_CS*PAGE_W-1:0]      CS_BASE = {NUM_CS{8'h00}},
  parameter logic [NUM_CS*PAGE_W-1:0]      CS_MASK = {NUM_CS{8'hFF}},
  parameter logic [NUM_CS*WAIT_W-1:0]      CS_WAIT = {NUM_CS{4'd0}},
  parameter int unsigned                   LED_W   = 16
) (
  input  logic              HSCLK,
  input  logic              RST_B,
  input  logic              ECLK,
  input  logic              QCLK,
  input  logic [15:0]       A,
  input  logic              BS,
  input  logic              BA,
  output logic [NUM_CS-1:0] CS_B,
  output logic              MRDY,
  output logic              SYS_A8,
  output logic              BUSACK_LED_B,
  output logic              IACK_LED_B
);

  localparam int unsigned WIN_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam logic [63:0] BASE_X = 64'(CS_BASE);
  localparam logic [63:0] MASK_X = 64'(CS_MASK);
  localparam logic [63:0] WAIT_X = 64'(CS_WAIT);

  logic             hit;
  logic [WIN_W-1:0] win;
  logic [WAIT_W-1:0] win_wait;
  logic             need_wait;
  logic             mrdy_c;
  logic             unused_ok;

  wait_state_e       state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              e_dly_q, e_dly_d;
  logic              ba_q, ba_d;

  // Lowest-index window wins; search stops at the first match.
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (!hit &&
          ((A[15:8] & field_get(MASK_X, i, PAGE_W)) ==
           (field_get(BASE_X, i, PAGE_W) & field_get(MASK_X, i, PAGE_W)))) begin
        hit = 1'b1;
        win = WIN_W'(i);
      end
    end
    hit = hit & ~BA & RST_B;
  end

  always_comb begin
    win_wait  = WAIT_W'(field_get(WAIT_X, 32'(win), WAIT_W));
    need_wait = hit && (win_wait != '0);
  end

  always_comb begin
    CS_B = '1;
    if (hit) begin
      CS_B[win] = 1'b0;
    end
  end

  // Counter holds remaining cycles minus one; MRDY rises once it has reached zero,
  // so a wait of N gives N low cycles including the combinational IDLE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    e_dly_d = ECLK;
    ba_d    = BA;
    mrdy_c  = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        mrdy_c = ~need_wait;
        if (need_wait) begin
          cnt_d   = win_wait - WAIT_W'(1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        mrdy_c = (cnt_q == '0);
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      ST_DONE: begin
        if (e_dly_q && !ECLK) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (BA && !ba_q) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    MRDY = mrdy_c | ~RST_B;
  end

  always_ff @(posedge HSCLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      e_dly_q <= 1'b0;
      ba_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_dly_q <= e_dly_d;
      ba_q    <= ba_d;
    end
  end

`ifdef M6809_SYSCTL_VECTOR_REMAP_EN
  always_comb SYS_A8 = A[8] ^ (BS & ~BA);
`else
  always_comb SYS_A8 = A[8];
`endif

  always_comb unused_ok = &{1'b0, QCLK, A[7:0]};

  m6809_led_stretch #(.LED_W(LED_W)) u_busack_led (
    .HSCLK    (HSCLK),
    .RST_B    (RST_B),
    .event_in (BA),
    .led_b    (BUSACK_LED_B)
  );

  m6809_led_stretch #(.LED_W(LED_W)) u_iack_led (
    .HSCLK    (HSCLK),
    .RST_B    (RST_B),
    .event_in (BS & ~BA),
    .led_b    (IACK_LED_B)
  );

endmodule

// File: doc/m6809_sysctl.md
# m6809_sysctl

Parametrised system-control block for the 6809 CPU card CPLD, successor to the fixed decode/remap logic. Decodes NUM_CS address-page windows into active-low chip selects, inserts per-window wait states by holding MRDY low for a programmed number of HSCLK cycles, optionally remaps interrupt-vector fetches via SYS_A8, and drives stretched activity LEDs for bus-grant and interrupt-acknowledge. Sits between the MC6809 pins and the 50-way system connector.

## Interface
- NUM_CS, 4: number of chip-select windows (1..8).
- CS_BASE, {NUM_CS{8'h00}}: packed NUM_CS x 8; window i base page compared against A[15:8].
- CS_MASK, {NUM_CS{8'hFF}}: packed NUM_CS x 8; window i compare mask (1 = bit compared).
- CS_WAIT, {NUM_CS{4'd0}}: packed NUM_CS x 4; window i wait length in HSCLK cycles (0 = no stretch).
- LED_W, 16: LED stretch counter width.
- HSCLK  in  1  system clock (also the 6809 EXTAL source); all state on rising edge.
- RST_B  in  1  asynchronous, active-low reset.
- ECLK  in  1  6809 E, synchronous to HSCLK.
- QCLK  in  1  6809 Q, synchronous to HSCLK.
- A  in  16  CPU address.
- BS, BA  in  1 each  6809 bus status.
- CS_B  out  NUM_CS  active-low chip selects.
- MRDY  out  1  memory ready to CPU; low stretches the cycle.
- SYS_A8  out  1  address bit 8 to the system bus.
- BUSACK_LED_B  out  1  active-low LED, bus granted.
- IACK_LED_B  out  1  active-low LED, vector fetch.

## Operation
- Address valid when BA=0. Window i hits when (A[15:8] & CS_MASK[i]) == (CS_BASE[i] & CS_MASK[i]). Lowest index wins; at most one CS_B low.
- CS_B combinational: low for winning window while BA=0 and RST_B=1; all high otherwise.
- Wait FSM states IDLE, WAIT, DONE.
  - IDLE: MRDY = ~(hit & CS_WAIT[win]!=0) combinationally; on HSCLK edge with such hit, load counter with CS_WAIT[win]-1, go WAIT.
  - WAIT: MRDY=0; counter decrements; at 0 go DONE.
  - DONE: MRDY=1; leave to IDLE on the edge where registered E (e_d) is 1 and ECLK is 0 (E falling).
  - BA rising in any state: go IDLE, MRDY=1.
- Vector fetch = BS=1 & BA=0. BUSACK event = BA=1.
- LED stretcher: event loads counter to all-ones; counter decrements to 0 otherwise; LED_B low while counter nonzero or event present. Event held continuously keeps counter saturated.

## Timing
- Reset values: MRDY=1, CS_B all 1, BUSACK_LED_B=1, IACK_LED_B=1, FSM IDLE, counters 0, e_d=0.
- MRDY falls in the same HSCLK cycle the address hits (combinational); stays low exactly CS_WAIT[win] HSCLK cycles, rises on the edge the counter reaches 0.
- CS_WAIT=1: one cycle low, IDLE->WAIT->DONE.
- Address change during WAIT does not restart or abort the count; window/count latched at IDLE exit.
- RST_B asserted mid-wait: MRDY high immediately (async).
- LED: LED_B low for 2^LED_W-1 HSCLK cycles after a single-cycle event ends, plus the event cycle.

## Configuration
- M6809_SYSCTL_VECTOR_REMAP_EN defined: SYS_A8 = A8 ^ (BS & ~BA), moving FFFx vectors to FEFx.
- Not defined: SYS_A8 = A8; IACK LED still functional.

## Structure
- Package m6809_sysctl_pkg: FSM state enum, PAGE_W=8, WAIT_W=4, field-extract helper for packed parameter arrays.
- Sub-module m6809_led_stretch (parameter LED_W; ports HSCLK, RST_B, event, led_b), instanced twice.
- Decode, FSM, SYS_A8 in top.

## Test plan
- Reset: RST_B low with A=16'hFC00 -> all CS_B=1, MRDY=1, both LED_B=1.
- CS_BASE[1]=8'hFC, CS_MASK[1]=8'hFC, CS_WAIT[1]=3, A=16'hFD10, BA=0 -> CS_B=4'b1101, MRDY low 3 HSCLK cycles, high until E falls, IDLE.
- Overlap: windows 0 and 2 both match A -> only CS_B[0] low, window 0 wait used.
- BA=1 during WAIT -> CS_B all high, MRDY=1 next edge, BUSACK_LED_B low 2^LED_W-1 cycles after BA drops (LED_W=4: 15).
- BS=1, BA=0, A=16'hFFFE with macro -> SYS_A8=0, IACK_LED_B low; without macro -> SYS_A8=1, IACK_LED_B low.
- RST_B low at WAIT count 2 -> MRDY=1 immediately; after release, FSM IDLE, next hit waits full CS_WAIT.
